// File: rtl/icache_responder.sv
// Direct-mapped 256-set x 16-byte instruction cache answering pre-IF fetch requests.
// Latency: hit data one cycle after the accepting edge; zero-wait miss returns six cycles after that.
// Backpressure: icache_busy is high while a miss is detected or refilling; requests seen while busy are dropped.
module icache_responder (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_valid,
    input  logic [7:0]  inst_index,
    input  logic [19:0] inst_tag,
    input  logic [3:0]  inst_offset,
    output logic        icache_busy,
    output logic [31:0] inst_rdata,
    output logic        inst_rdata_valid,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    input  logic        rd_rdy,
    input  logic        ret_valid,
    input  logic        ret_last,
    input  logic [31:0] ret_data
);

    localparam int          LINE_WORDS = 4;
    localparam int          SETS       = 256;
    localparam int          WORD_W     = 32;
    localparam int          LINE_W     = LINE_WORDS * WORD_W;
    localparam logic [1:0]  LAST_BEAT  = 2'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS,
        S_REFILL,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    // Captured fetch request; stays put for the whole miss because accepts are blocked while busy.
    logic [19:0] req_tag_q,  req_tag_d;
    logic [7:0]  req_idx_q,  req_idx_d;
    logic [1:0]  req_word_q, req_word_d;

    // Refill beat position and the line being assembled from return beats.
    logic [1:0]        cnt_q, cnt_d;
    logic [LINE_W-1:0] line_buf_q, line_buf_d;

    // Cache storage: only the valid bits need a reset value.
    logic [SETS-1:0]   valid_q;
    logic [19:0]       tag_q  [SETS];
    logic [LINE_W-1:0] data_q [SETS];

    logic              accept;
    logic              hit;
    logic              fill_we;
    logic [19:0]       rd_tag;
    logic [LINE_W-1:0] rd_line;

    // The byte-within-word bits carry no information for a word-aligned fetch.
    logic unused_offset_bits;
    assign unused_offset_bits = ^inst_offset[1:0];

    assign rd_tag  = tag_q[req_idx_q];
    assign rd_line = data_q[req_idx_q];
    assign hit     = valid_q[req_idx_q] && (rd_tag == req_tag_q);

    // Busy only while a miss is pending; hit and fill-completion cycles take the next request.
    assign icache_busy = ((state_q == S_LOOKUP) && !hit)
                       || (state_q == S_MISS)
                       || (state_q == S_REFILL);
    assign accept      = inst_valid && !icache_busy;

    // Request register next-state: load on every accepted fetch.
    always_comb begin
        req_tag_d  = req_tag_q;
        req_idx_d  = req_idx_q;
        req_word_d = req_word_q;
        if (accept) begin
            req_tag_d  = inst_tag;
            req_idx_d  = inst_index;
            req_word_d = inst_offset[3:2];
        end
    end

    // FSM next-state, refill datapath and all response/memory outputs.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        line_buf_d       = line_buf_q;
        fill_we          = 1'b0;
        rd_req           = 1'b0;
        rd_addr          = '0;
        inst_rdata       = '0;
        inst_rdata_valid = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_LOOKUP;
                end
            end

            S_LOOKUP: begin
                if (hit) begin
                    inst_rdata       = rd_line[{req_word_q, 5'b0} +: WORD_W];
                    inst_rdata_valid = 1'b1;
                    state_d          = accept ? S_LOOKUP : S_IDLE;
                end else begin
                    state_d = S_MISS;
                end
            end

            S_MISS: begin
                rd_req  = 1'b1;
                rd_addr = {req_tag_q, req_idx_q, 4'b0000};
                if (rd_rdy) begin
                    cnt_d   = 2'd0;
                    state_d = S_REFILL;
                end
            end

            S_REFILL: begin
                if (ret_valid) begin
                    line_buf_d[{cnt_q, 5'b0} +: WORD_W] = ret_data;
                    cnt_d = cnt_q + 2'd1;
                    // Either the memory flags the end or the fourth beat closes the line.
                    if (ret_last || (cnt_q == LAST_BEAT)) begin
                        state_d = S_RESP;
                    end
                end
            end

            S_RESP: begin
                fill_we          = 1'b1;
                inst_rdata       = line_buf_q[{req_word_q, 5'b0} +: WORD_W];
                inst_rdata_valid = 1'b1;
                state_d          = accept ? S_LOOKUP : S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state: FSM, beat counter, request capture and valid bits, cleared by reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            cnt_q      <= 2'd0;
            req_tag_q  <= '0;
            req_idx_q  <= '0;
            req_word_q <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_tag_q  <= req_tag_d;
            req_idx_q  <= req_idx_d;
            req_word_q <= req_word_d;
            if (fill_we) begin
                valid_q[req_idx_q] <= 1'b1;
            end
        end
    end

    // Tag/data arrays and line buffer carry no reset; valid bits guard their contents.
    always_ff @(posedge clk) begin
        line_buf_q <= line_buf_d;
        if (fill_we) begin
            tag_q[req_idx_q]  <= req_tag_q;
            data_q[req_idx_q] <= line_buf_q;
        end
    end

    // The memory side relies on a stable address while a read request waits for rd_rdy.
    a_rd_addr_stable : assert property (
        @(posedge clk) disable iff (!resetn)
        (rd_req && !rd_rdy) |=> (rd_req && $stable(rd_addr))
    );

    // A response is never presented in a cycle that also refuses new requests.
    a_no_resp_while_busy : assert property (
        @(posedge clk) disable iff (!resetn)
        !(inst_rdata_valid && icache_busy)
    );

endmodule
